// File: rtl/root_hub_switch.sv
// Root-side switch: merges per-leaf upstream FIFOs into one tagged core stream
// (round-robin) and routes core words downstream as unicast, broadcast or drop.
module root_hub_switch #(
    parameter int NUM_LEAVES = 2,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_LEAVES*DATA_WIDTH-1:0] leaf_rx_data,
    input  logic [NUM_LEAVES-1:0]            leaf_rx_valid,
    output logic [NUM_LEAVES-1:0]            leaf_rx_ready,
    output logic [NUM_LEAVES*DATA_WIDTH-1:0] leaf_tx_data,
    output logic [NUM_LEAVES-1:0]            leaf_tx_valid,
    input  logic [NUM_LEAVES-1:0]            leaf_tx_ready,
    output logic [DATA_WIDTH-1:0]            core_rx_data,
    output logic [$clog2(NUM_LEAVES):0]      core_rx_src,
    output logic                             core_rx_valid,
    input  logic                             core_rx_ready,
    input  logic [DATA_WIDTH-1:0]            core_tx_data,
    input  logic                             core_tx_valid,
    output logic                             core_tx_ready,
    output logic [CNT_WIDTH-1:0]             drop_count
);

    localparam int SRC_W = $clog2(NUM_LEAVES) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UNICAST = 2'd1,
        ST_BCAST   = 2'd2
    } state_t;

    logic [NUM_LEAVES-1:0] w_push;
    logic [NUM_LEAVES-1:0] w_pop;
    logic [NUM_LEAVES-1:0] w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_head [NUM_LEAVES];

    logic                  w_arb_run;
    logic                  w_grant_vld;
    logic [SRC_W-1:0]      w_grant_idx;
    logic [SRC_W-1:0]      w_next_ptr;
    logic [SRC_W-1:0]      r_arb_ptr;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SRC_W-1:0]      r_out_src;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_LEAVES-1:0] r_mask;
    logic [NUM_LEAVES-1:0] w_mask_nxt;
    logic [NUM_LEAVES-1:0] w_onehot;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  w_load;
    logic                  w_drop;
    logic [7:0]            w_dest;
    logic                  r_core_tx_ready;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_fifo
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]      r_wr_ptr;
        logic [PTR_W-1:0]      r_rd_ptr;
        logic [PTR_W:0]        r_count;

        assign w_push[g]        = leaf_rx_valid[g] && leaf_rx_ready[g];
        assign w_pop[g]         = w_grant_vld && (w_grant_idx == SRC_W'(g));
        assign w_fifo_empty[g]  = (r_count == '0);
        assign leaf_rx_ready[g] = (r_count != FULL_CNT);
        assign w_head[g]        = r_mem[r_rd_ptr];

        // Storage array; contents need no reset because occupancy is tracked separately.
        always_ff @(posedge clk) begin
            if (w_push[g]) begin
                r_mem[r_wr_ptr] <= leaf_rx_data[g*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Pointers wrap naturally because the depth is a power of two.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[g]) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop[g]) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push[g], w_pop[g]})
                    2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_arb_run  = !r_out_valid || core_rx_ready;
    assign w_next_ptr = (w_grant_idx == SRC_W'(NUM_LEAVES - 1)) ? '0 : w_grant_idx + SRC_W'(1);

    // Search from ptr downward in reverse so the nearest non-empty leaf is written last and wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_LEAVES - 1; k >= 0; k--) begin
            if (w_arb_run && !w_fifo_empty[(int'(r_arb_ptr) + k) % NUM_LEAVES]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = SRC_W'((int'(r_arb_ptr) + k) % NUM_LEAVES);
            end else begin
                w_grant_vld = w_grant_vld;
            end
        end
    end

    // Upstream output register and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_arb_ptr   <= '0;
        end else if (w_grant_vld) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head[w_grant_idx];
            r_out_src   <= w_grant_idx + SRC_W'(1);
            r_arb_ptr   <= w_next_ptr;
        end else if (core_rx_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_dest   = core_tx_data[DATA_WIDTH-1 -: 8];
    assign w_onehot = NUM_LEAVES'(1) << (w_dest - 8'd1);

    // Downstream next-state: a word is held until every addressed leaf has taken it.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (core_tx_valid) begin
                    if ((w_dest != 8'd0) && (int'(w_dest) <= NUM_LEAVES)) begin
                        w_state_nxt = ST_UNICAST;
                        w_mask_nxt  = w_onehot;
                        w_load      = 1'b1;
                    end else if (w_dest == 8'hFF) begin
                        w_state_nxt = ST_BCAST;
                        w_mask_nxt  = '1;
                        w_load      = 1'b1;
                    end else begin
                        w_drop      = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_UNICAST, ST_BCAST: begin
                w_mask_nxt = r_mask & ~leaf_tx_ready;
                if (w_mask_nxt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mask_nxt  = '0;
            end
        endcase
    end

    // Downstream state, latched word, pending mask and saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_mask          <= '0;
            r_word          <= '0;
            r_core_tx_ready <= 1'b1;
            r_drop_cnt      <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_mask          <= w_mask_nxt;
            r_core_tx_ready <= (w_state_nxt == ST_IDLE);
            if (w_load) begin
                r_word <= core_tx_data;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign core_rx_valid = r_out_valid;
    assign core_rx_data  = r_out_data;
    assign core_rx_src   = r_out_src;
    assign leaf_tx_valid = r_mask;
    assign leaf_tx_data  = {NUM_LEAVES{r_word}};
    assign core_tx_ready = r_core_tx_ready;
    assign drop_count    = r_drop_cnt;

endmodule

// File: tb/tb_root_hub_switch.sv
// Self-checking bench for root_hub_switch: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_root_hub_switch;

    localparam int N  = 2;
    localparam int W  = 64;
    localparam int D  = 4;
    localparam int CW = 4;
    localparam int SW = 2;

    logic              clk;
    logic              reset;
    logic [N*W-1:0]    leaf_rx_data;
    logic [N-1:0]      leaf_rx_valid;
    logic [N-1:0]      leaf_rx_ready;
    logic [N*W-1:0]    leaf_tx_data;
    logic [N-1:0]      leaf_tx_valid;
    logic [N-1:0]      leaf_tx_ready;
    logic [W-1:0]      core_rx_data;
    logic [SW-1:0]     core_rx_src;
    logic              core_rx_valid;
    logic              core_rx_ready;
    logic [W-1:0]      core_tx_data;
    logic              core_tx_valid;
    logic              core_tx_ready;
    logic [CW-1:0]     drop_count;

    root_hub_switch #(.NUM_LEAVES(N), .DATA_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .leaf_rx_data(leaf_rx_data), .leaf_rx_valid(leaf_rx_valid), .leaf_rx_ready(leaf_rx_ready),
        .leaf_tx_data(leaf_tx_data), .leaf_tx_valid(leaf_tx_valid), .leaf_tx_ready(leaf_tx_ready),
        .core_rx_data(core_rx_data), .core_rx_src(core_rx_src), .core_rx_valid(core_rx_valid),
        .core_rx_ready(core_rx_ready), .core_tx_data(core_tx_data), .core_tx_valid(core_tx_valid),
        .core_tx_ready(core_tx_ready), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    typedef logic [W-1:0] word_q_t [$];
    word_q_t     mq [N];
    logic        m_out_v;
    logic [W-1:0] m_out_d;
    int          m_out_s;
    int          m_ptr;
    logic [N-1:0] m_mask;
    logic [W-1:0] m_word;
    int          m_drop;
    logic [N-1:0] m_pushed;
    logic        m_tx_acc;
    int          seq = 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) mq[n].delete();
        m_out_v  = 1'b0;
        m_out_d  = '0;
        m_out_s  = 0;
        m_ptr    = 0;
        m_mask   = '0;
        m_word   = '0;
        m_drop   = 0;
        m_pushed = '0;
        m_tx_acc = 1'b0;
    endtask

    task automatic model_edge();
        int d;
        int g;
        bit found;
        m_pushed = '0;
        m_tx_acc = 1'b0;
        if (!reset) begin
            model_reset();
        end else begin
            for (int n = 0; n < N; n++) m_pushed[n] = leaf_rx_valid[n] && (mq[n].size() < D);
            if (!m_out_v || core_rx_ready) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    g = (m_ptr + k) % N;
                    if (!found && mq[g].size() > 0) begin
                        found   = 1'b1;
                        m_out_d = mq[g].pop_front();
                        m_out_s = g + 1;
                        m_ptr   = (g + 1) % N;
                    end
                end
                m_out_v = found;
            end
            for (int n = 0; n < N; n++)
                if (m_pushed[n]) mq[n].push_back(leaf_rx_data[n*W +: W]);
            if (m_mask == '0) begin
                if (core_tx_valid) begin
                    m_tx_acc = 1'b1;
                    d = int'(core_tx_data[W-1 -: 8]);
                    if (d >= 1 && d <= N) begin
                        m_mask = '0;
                        m_mask[d-1] = 1'b1;
                        m_word = core_tx_data;
                    end else if (d == 255) begin
                        m_mask = '1;
                        m_word = core_tx_data;
                    end else if (m_drop < (1 << CW) - 1) begin
                        m_drop++;
                    end
                end
            end else begin
                m_mask = m_mask & ~leaf_tx_ready;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] exp_rdy;
        check_val("rx_valid", 64'(core_rx_valid), 64'(m_out_v));
        if (m_out_v) begin
            check_val("rx_data", core_rx_data, m_out_d);
            check_val("rx_src", 64'(core_rx_src), 64'(m_out_s));
        end
        for (int n = 0; n < N; n++) exp_rdy[n] = (mq[n].size() < D);
        check_val("rx_ready", 64'(leaf_rx_ready), 64'(exp_rdy));
        check_val("tx_valid", 64'(leaf_tx_valid), 64'(m_mask));
        check_val("tx_ready", 64'(core_tx_ready), 64'(m_mask == '0));
        check_val("drop_cnt", 64'(drop_count), 64'(m_drop));
        for (int n = 0; n < N; n++)
            if (m_mask[n]) check_val("tx_data", leaf_tx_data[n*W +: W], m_word);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    function automatic logic [W-1:0] mk_word(input int leaf);
        seq++;
        return {8'(leaf), 24'h0, 32'(seq)};
    endfunction

    logic [7:0] dests [6];
    int rx_pct, tx_pct, crr_pct;

    task automatic drive_random();
        for (int n = 0; n < N; n++) begin
            if (!leaf_rx_valid[n] || m_pushed[n]) begin
                leaf_rx_valid[n] = ($urandom_range(0, 99) < rx_pct);
                leaf_rx_data[n*W +: W] = mk_word(n);
            end
        end
        if (!core_tx_valid || m_tx_acc) begin
            core_tx_valid = ($urandom_range(0, 99) < tx_pct);
            core_tx_data  = {dests[$urandom_range(0, 5)], 24'($urandom), 32'($urandom)};
        end
        core_rx_ready = ($urandom_range(0, 99) < crr_pct);
        leaf_tx_ready = N'($urandom);
    endtask

    int acc;
    int prev_src;

    initial begin
        dests[0] = 8'h00; dests[1] = 8'h01; dests[2] = 8'h02;
        dests[3] = 8'h03; dests[4] = 8'h07; dests[5] = 8'hFF;
        reset = 1'b0;
        leaf_rx_data = '0; leaf_rx_valid = '0; leaf_tx_ready = '0;
        core_rx_ready = 1'b0; core_tx_data = '0; core_tx_valid = 1'b0;
        model_reset();
        tick(); tick();
        check_val("rst_rx_valid", 64'(core_rx_valid), 64'h0);
        check_val("rst_rx_ready", 64'(leaf_rx_ready), 64'h3);
        check_val("rst_tx_valid", 64'(leaf_tx_valid), 64'h0);
        check_val("rst_tx_ready", 64'(core_tx_ready), 64'h1);
        check_val("rst_rx_data", core_rx_data, 64'h0);
        check_val("rst_rx_src", 64'(core_rx_src), 64'h0);
        check_val("rst_drop", 64'(drop_count), 64'h0);
        reset = 1'b1;

        // Latency: one word from leaf 0
        core_rx_ready = 1'b1;
        leaf_rx_valid[0] = 1'b1;
        leaf_rx_data[0 +: W] = 64'h0000_0000_0000_00A1;
        tick();
        leaf_rx_valid[0] = 1'b0;
        check_val("lat_early", 64'(core_rx_valid), 64'h0);
        tick();
        check_val("lat_valid", 64'(core_rx_valid), 64'h1);
        check_val("lat_data", core_rx_data, 64'h0000_0000_0000_00A1);
        check_val("lat_src", 64'(core_rx_src), 64'h1);
        tick();

        // Both leaves streaming: sources must alternate
        prev_src = 0;
        for (int i = 0; i < 20; i++) begin
            for (int n = 0; n < N; n++) begin
                if (!leaf_rx_valid[n] || m_pushed[n]) begin
                    leaf_rx_valid[n] = 1'b1;
                    leaf_rx_data[n*W +: W] = mk_word(n);
                end
            end
            tick();
            if (i > 2) begin
                if (prev_src != 0) check_val("alt_src", 64'(core_rx_src), (prev_src == 1) ? 64'h2 : 64'h1);
                prev_src = int'(core_rx_src);
            end
        end
        leaf_rx_valid = '0;
        for (int i = 0; i < 12; i++) tick();

        // Back-pressure: leaf 1 fills FIFO plus output register
        core_rx_ready = 1'b0;
        acc = 0;
        leaf_rx_valid[1] = 1'b1;
        leaf_rx_data[W +: W] = mk_word(1);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (m_pushed[1]) begin
                acc++;
                leaf_rx_data[W +: W] = mk_word(1);
            end
        end
        check_val("bp_accepted", 64'(acc), 64'd5);
        check_val("bp_ready", 64'(leaf_rx_ready[1]), 64'h0);
        leaf_rx_valid = '0;
        core_rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_val("bp_drained", 64'(core_rx_valid), 64'h0);

        // Broadcast with staggered acceptance
        leaf_tx_ready = 2'b00;
        core_tx_valid = 1'b1;
        core_tx_data  = {8'hFF, 56'h00_1234_5678_9ABC};
        tick();
        core_tx_valid = 1'b0;
        check_val("bc_mask11", 64'(leaf_tx_valid), 64'h3);
        leaf_tx_ready = 2'b01;
        tick();
        check_val("bc_mask10", 64'(leaf_tx_valid), 64'h2);
        check_val("bc_busy", 64'(core_tx_ready), 64'h0);
        leaf_tx_ready = 2'b10;
        tick();
        check_val("bc_mask00", 64'(leaf_tx_valid), 64'h0);
        check_val("bc_idle", 64'(core_tx_ready), 64'h1);

        // Unicast to leaf 2, then an out-of-range destination
        leaf_tx_ready = 2'b00;
        core_tx_valid = 1'b1;
        core_tx_data  = {8'h02, 56'h00_0000_0000_0B0B};
        tick();
        core_tx_valid = 1'b0;
        check_val("uc_mask", 64'(leaf_tx_valid), 64'h2);
        leaf_tx_ready = 2'b10;
        tick();
        leaf_tx_ready = 2'b00;
        core_tx_valid = 1'b1;
        core_tx_data  = {8'h07, 56'h0};
        tick();
        core_tx_valid = 1'b0;
        check_val("drop_mask", 64'(leaf_tx_valid), 64'h0);
        check_val("drop_one", 64'(drop_count), 64'h1);

        // Reset during broadcast with words buffered upstream
        core_rx_ready = 1'b0;
        leaf_rx_valid = 2'b11;
        leaf_rx_data  = {mk_word(1), mk_word(0)};
        tick(); tick(); tick();
        leaf_rx_valid = '0;
        core_tx_valid = 1'b1;
        core_tx_data  = {8'hFF, 56'h0};
        tick();
        core_tx_valid = 1'b0;
        leaf_tx_ready = 2'b01;
        tick();
        check_val("mr_mask10", 64'(leaf_tx_valid), 64'h2);
        reset = 1'b0;
        #1;
        model_reset();
        check_val("mr_tx_valid", 64'(leaf_tx_valid), 64'h0);
        check_val("mr_tx_ready", 64'(core_tx_ready), 64'h1);
        check_val("mr_rx_valid", 64'(core_rx_valid), 64'h0);
        check_val("mr_rx_ready", 64'(leaf_rx_ready), 64'h3);
        check_val("mr_drop", 64'(drop_count), 64'h0);
        tick(); tick();
        reset = 1'b1;
        core_rx_ready = 1'b1;
        tick(); tick(); tick();
        check_val("mr_empty", 64'(core_rx_valid), 64'h0);

        // Randomized traffic on both paths
        for (int ph = 0; ph < 8; ph++) begin
            rx_pct  = $urandom_range(20, 100);
            tx_pct  = $urandom_range(20, 100);
            crr_pct = $urandom_range(10, 100);
            for (int i = 0; i < 200; i++) begin
                drive_random();
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
